// File: rtl/encoder_scan_mxn.sv
// encoder_scan_mxn
// Registered, handshaked successor to the combinational m-to-n encoder.
// Accepts a 2**SIZE-bit request vector with any number of asserted bits and
// emits the binary index of every asserted bit, lowest index first, one index
// per accepted output beat, flagging the final index with out_last.
//
// Parameters:
//   SIZE        index width; request vector is 2**SIZE bits wide
//   ACTIVE_LOW  1 = a request bit is asserted when 0, 0 = asserted when 1
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   request vector valid
//   in_ready   block can accept a vector (high only while idle)
//   in_vec     request vector, polarity set by ACTIVE_LOW
//   out_valid  out_idx/out_last valid
//   out_ready  consumer accepts the current index
//   out_idx    index of the current asserted bit
//   out_last   current index is the final one of this vector
//   empty_err  one-cycle pulse: the accepted vector had no asserted bit
//   busy       high while indices are being emitted
//   pop_cnt    (only with ENC_POPCOUNT_EN defined) number of asserted bits
//              in the most recently accepted vector
//
// Optional feature macro: ENC_POPCOUNT_EN

module encoder_scan_mxn #(
  parameter int SIZE       = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2**SIZE-1:0]   in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      out_idx,
  output logic                 out_last,
  output logic                 empty_err,
  output logic                 busy
`ifdef ENC_POPCOUNT_EN
  ,
  output logic [SIZE:0]        pop_cnt
`endif
);

  localparam int N = 2**SIZE;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state;
  state_t          state_next;
  logic [N-1:0]    norm;
  logic [N-1:0]    pend;
  logic [N-1:0]    src;
  logic [N-1:0]    src_clr;
  logic            src_single;
  logic [SIZE-1:0] low_idx;

  assign norm = ACTIVE_LOW ? ~in_vec : in_vec;

  // One shared search serves both states: in IDLE it looks at the incoming
  // vector, in SCAN at the bits still pending.
  always_comb begin
    src        = (state == IDLE) ? norm : pend;
    src_clr    = src & (src - N'(1));
    src_single = (src != '0) && (src_clr == '0);
  end

  // Priority encoder: the loop runs high to low so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) low_idx = SIZE'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. An empty vector is accepted but never enters SCAN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid && (norm != '0))   state_next = SCAN;
      SCAN: if (out_ready && out_last)      state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == SCAN);
  end

  // Output beat registers and pending-bit store. out_idx/out_last only move
  // on a consumed beat, so they hold steady through any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      empty_err <= 1'b0;
    end else begin
      empty_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (norm == '0) begin
              empty_err <= 1'b1;
            end else begin
              pend      <= src_clr;
              out_idx   <= low_idx;
              out_last  <= src_single;
              out_valid <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              pend      <= '0;
            end else begin
              pend     <= src_clr;
              out_idx  <= low_idx;
              out_last <= src_single;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENC_POPCOUNT_EN
  logic [SIZE:0] norm_cnt;

  always_comb begin
    norm_cnt = '0;
    for (int i = 0; i < N; i++) begin
      norm_cnt = norm_cnt + {{SIZE{1'b0}}, norm[i]};
    end
  end

  // Captured on every acceptance, including empty vectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           pop_cnt <= '0;
    else if (in_valid && in_ready)     pop_cnt <= norm_cnt;
  end
`endif

endmodule
